// File: rtl/uart_io_nios2_qsys_ocimem_seq_if.sv
// Memory-side bus of the OCI memory sequencer. The sequencer is the master.
// The master raises exactly one of mem_read/mem_write and holds it, together with
// mem_addr and mem_wdata, stable until the slave pulses mem_ack for one cycle or the
// master gives up. mem_rdata is meaningful only in the cycle mem_ack is high.
interface uart_io_nios2_qsys_ocimem_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/uart_io_nios2_qsys_ocimem_seq.sv
// OCI memory access sequencer: turns debugger command pulses into single memory
// read/write requests with auto-increment, a bounded wait for ack, and status flags.
module uart_io_nios2_qsys_ocimem_seq #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [37:0] jdo,
    uart_io_nios2_qsys_ocimem_seq_if.master mem,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [7:0]        wait_cnt;
    logic              cmd_any;
    logic              unused_jdo;

    assign cmd_any    = take_action_ocimem_a | take_action_ocimem_b;
    // Only some jdo fields matter; the rest of the JTAG word is deliberately ignored.
    assign unused_jdo = ^jdo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            wdata         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Command a has priority; a simultaneous b is dropped and flagged.
                    if (take_action_ocimem_a) begin
                        addr          <= jdo[ADDR_W+25:26];
                        wait_cnt      <= '0;
                        monitor_ready <= 1'b0;
                        monitor_error <= take_action_ocimem_b;
                        state         <= jdo[25] ? READ : IDLE;
                    end else if (take_action_ocimem_b) begin
                        wdata         <= jdo[34:3];
                        wait_cnt      <= '0;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        state         <= WRITE;
                    end
                end
                READ, WRITE: begin
                    // An ack in the last allowed cycle still counts as a completion.
                    if (mem.mem_ack) begin
                        if (state == READ) begin
                            MonDReg <= mem.mem_rdata;
                        end
                        monitor_ready <= 1'b1;
                        addr          <= addr + ADDR_W'(1);
                        state         <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        monitor_error <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    if (cmd_any) begin
                        monitor_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
    assign mem.mem_read  = (state == READ);
    assign mem.mem_write = (state == WRITE);
    assign busy          = (state != IDLE);
    assign state_dbg     = state;
endmodule

// File: tb/tb_uart_io_nios2_qsys_ocimem_seq.sv
// Bench for the OCI memory sequencer: memory responder, reference model with
// expected-result queue, completion monitor and directed plus random command traffic.
module tb_uart_io_nios2_qsys_ocimem_seq;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 255;

    typedef struct packed {
        logic        is_read;
        logic [7:0]  cycles;
        logic [7:0]  addr;
        logic [31:0] mondreg;
        logic [31:0] wdata;
        logic        ready;
        logic        error;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic        clk;
    logic        reset_n;
    logic        take_a;
    logic        take_b;
    logic [37:0] jdo;
    logic [31:0] mon_d_reg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;
    logic [1:0]  state_dbg;

    uart_io_nios2_qsys_ocimem_seq_if #(.ADDR_W(8)) mem_bus ();

    uart_io_nios2_qsys_ocimem_seq #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .jdo                  (jdo),
        .mem                  (mem_bus),
        .MonDReg              (mon_d_reg),
        .monitor_ready        (monitor_ready),
        .monitor_error        (monitor_error),
        .busy                 (busy),
        .state_dbg            (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [31:0] mem_model [256];
    logic [31:0] ref_mem   [256];
    int          ack_at   = NO_ACK;
    logic        idle_ack = 1'b0;

    // reference model state
    logic [7:0]  ref_addr    = 8'd0;
    logic [31:0] ref_mondreg = 32'd0;
    logic [31:0] ref_wdata   = 32'd0;
    logic        ref_ready   = 1'b0;
    logic        ref_error   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        int req_n;
        req_n = 0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (reset_n && (mem_bus.mem_read || mem_bus.mem_write)) begin
                req_n++;
                if (req_n == ack_at) begin
                    mem_bus.mem_ack = 1'b1;
                    if (mem_bus.mem_read) mem_bus.mem_rdata = mem_model[mem_bus.mem_addr];
                    else                  mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
                end
            end else begin
                req_n = 0;
                if (idle_ack) mem_bus.mem_ack = 1'b1;
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin : monitor
        logic        prev_busy;
        int          req_cnt;
        logic        saw_rd, saw_wr;
        logic [31:0] seen_wdata;
        exp_t        e;
        prev_busy = 1'b0; req_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0; seen_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 1'b0; req_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
            end else begin
                if (mem_bus.mem_read || mem_bus.mem_write)
                    check("one_request_at_a_time", {63'd0, mem_bus.mem_read & mem_bus.mem_write}, 64'd0);
                if (mem_bus.mem_read)  begin req_cnt++; saw_rd = 1'b1; end
                if (mem_bus.mem_write) begin req_cnt++; saw_wr = 1'b1; seen_wdata = mem_bus.mem_wdata; end
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = exp_t'(exp_q.pop_front());
                        check("req_kind_read",  {63'd0, saw_rd}, {63'd0, e.is_read});
                        check("req_kind_write", {63'd0, saw_wr}, {63'd0, ~e.is_read});
                        check("req_cycles", 64'(req_cnt), 64'(e.cycles));
                        check("addr_after", 64'(mem_bus.mem_addr), 64'(e.addr));
                        check("mondreg",    64'(mon_d_reg), 64'(e.mondreg));
                        check("ready",      {63'd0, monitor_ready}, {63'd0, e.ready});
                        check("error",      {63'd0, monitor_error}, {63'd0, e.error});
                        if (!e.is_read) check("wdata_during_req", 64'(seen_wdata), 64'(e.wdata));
                    end
                    req_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [37:0] rand_jdo();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[37:0];
    endfunction

    task automatic pulse(input logic pa, input logic pb, input logic [37:0] j);
        @(posedge clk); #1;
        take_a = pa; take_b = pb; jdo = j;
        @(posedge clk); #1;
        take_a = 1'b0; take_b = 1'b0; jdo = rand_jdo();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (busy && n < TIMEOUT + 10);
        if (busy) begin
            total++; bad++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_addr"},  64'(mem_bus.mem_addr), 64'(ref_addr));
        check({tag, "_mond"},  64'(mon_d_reg), 64'(ref_mondreg));
        check({tag, "_wdata"}, 64'(mem_bus.mem_wdata), 64'(ref_wdata));
        check({tag, "_ready"}, {63'd0, monitor_ready}, {63'd0, ref_ready});
        check({tag, "_error"}, {63'd0, monitor_error}, {63'd0, ref_error});
        check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    endtask

    task automatic set_addr(input logic [7:0] a);
        logic [37:0] j;
        j = rand_jdo(); j[33:26] = a; j[25] = 1'b0;
        ref_addr = a; ref_ready = 1'b0; ref_error = 1'b0;
        pulse(1'b1, 1'b0, j);
        @(negedge clk);
        check_status("set_addr");
    endtask

    // k = request cycle in which the memory acks (k > TIMEOUT means never)
    task automatic do_read(input logic [7:0] a, input int k, input logic collide);
        logic [37:0] j;
        exp_t e;
        j = rand_jdo(); j[33:26] = a; j[25] = 1'b1;
        ack_at = k;
        e.is_read = 1'b1;
        e.wdata   = ref_wdata;
        if (k <= TIMEOUT) begin
            e.cycles = 8'(k); ref_mondreg = ref_mem[a]; ref_addr = a + 8'd1;
            ref_ready = 1'b1; ref_error = collide;
        end else begin
            e.cycles = 8'(TIMEOUT); ref_addr = a; ref_ready = 1'b0; ref_error = 1'b1;
        end
        e.addr = ref_addr; e.mondreg = ref_mondreg; e.ready = ref_ready; e.error = ref_error;
        exp_q.push_back(e);
        pulse(1'b1, 1'b0, j);
        if (collide) pulse(1'b0, 1'b1, rand_jdo());
        wait_idle();
        ack_at = NO_ACK;
    endtask

    task automatic do_write(input logic [31:0] wd, input int k);
        logic [37:0] j;
        exp_t e;
        j = rand_jdo(); j[34:3] = wd;
        ack_at = k;
        ref_wdata = wd;
        e.is_read = 1'b0;
        e.wdata   = wd;
        if (k <= TIMEOUT) begin
            e.cycles = 8'(k); ref_mem[ref_addr] = wd; ref_addr = ref_addr + 8'd1;
            ref_ready = 1'b1; ref_error = 1'b0;
        end else begin
            e.cycles = 8'(TIMEOUT); ref_ready = 1'b0; ref_error = 1'b1;
        end
        e.addr = ref_addr; e.mondreg = ref_mondreg; e.ready = ref_ready; e.error = ref_error;
        exp_q.push_back(e);
        pulse(1'b0, 1'b1, j);
        wait_idle();
        ack_at = NO_ACK;
    endtask

    // ---------------- main sequence ----------------
    initial begin : stimulus
        logic [37:0] j;
        logic [31:0] v;
        int          k;
        reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; jdo = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; mem_model[i] = v; ref_mem[i] = v;
        end
        mem_model[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check_status("reset");
        check("reset_state", 64'(state_dbg), 64'd0);
        check("reset_rd_wr", {62'd0, mem_bus.mem_read, mem_bus.mem_write}, 64'd0);
        reset_n = 1'b1;

        // directed: read with ack in third request cycle
        do_read(8'h10, 3, 1'b0);
        // directed: write at the top address wraps to zero
        set_addr(8'hFF);
        do_write(32'h12345678, 2);
        // directed: timeout, then ack exactly in the final allowed cycle
        do_read(8'h22, NO_ACK, 1'b0);
        do_read(8'h23, TIMEOUT, 1'b0);
        // stray ack while idle changes nothing
        @(negedge clk); idle_ack = 1'b1;
        @(negedge clk); idle_ack = 1'b0;
        @(negedge clk);
        check_status("idle_ack");
        // collision: write command during a read, then both commands together
        do_read(8'h30, 5, 1'b1);
        check("collide_wdata", 64'(mem_bus.mem_wdata), 64'(ref_wdata));
        j = rand_jdo(); j[33:26] = 8'h5A; j[25] = 1'b0;
        ref_addr = 8'h5A; ref_ready = 1'b0; ref_error = 1'b1;
        pulse(1'b1, 1'b1, j);
        @(negedge clk);
        check_status("both_pulses");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                            : $urandom_range(1, 6);
            case ($urandom_range(0, 2))
                0: do_read(8'($urandom), k, 1'b0);
                1: do_write($urandom, k);
                default: begin
                    set_addr(8'($urandom));
                    do_write($urandom, k);
                end
            endcase
        end

        // reset in the middle of a write
        set_addr(8'h40);
        j = rand_jdo(); j[34:3] = 32'hCAFEF00D;
        ack_at = NO_ACK;
        pulse(1'b0, 1'b1, j);
        repeat (3) @(negedge clk);
        check("pre_reset_write", {63'd0, mem_bus.mem_write}, 64'd1);
        check("pre_reset_wdata", 64'(mem_bus.mem_wdata), 64'h0000_0000_CAFE_F00D);
        #2 reset_n = 1'b0;
        #1;
        ref_addr = 8'd0; ref_mondreg = 32'd0; ref_wdata = 32'd0; ref_ready = 1'b0; ref_error = 1'b0;
        check_status("mid_reset");
        check("mid_reset_rd_wr", {62'd0, mem_bus.mem_read, mem_bus.mem_write}, 64'd0);
        check("mid_reset_state", 64'(state_dbg), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_read(8'h05, 2, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
